preamble_generator: RTL and testbench
=====================================

Name: preamble_generator

Overview:
- Transmit-side test source for the CSI extraction chain. Emits 802.11 legacy training fields as 20 MSPS complex samples on AXI-Stream.
- Training fields: STS = 10 x 16-sample periods (160 samples). LTS = 32-sample GI2 followed by 2 x 64 samples (160 samples). A programmable run of zero samples follows.
- Drives the receiver's 20 MSPS input directly, or an upsampler feeding the full-rate input, for closed-loop bring-up and CSI verification.

Parameters:
- SAMPLE_WIDTH, 16, width of each of I and Q.
- GAP_WIDTH, 16, width of gap_len_in.
- FRAMES_WIDTH, 8, width of num_frames_in.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous, active-low reset.
- start_in  in  1  single-cycle start pulse; sampled only in IDLE.
- abort_in  in  1  stop at the next sample boundary.
- gap_len_in  in  GAP_WIDTH  number of zero samples after each LTS; latched at start.
- num_frames_in  in  FRAMES_WIDTH  frames to send; 0 = continuous; latched at start.
- busy_out  out  1  high from the cycle after an accepted start until the return to IDLE.
- frame_done_out  out  1  one-cycle pulse when the last beat of a frame is accepted.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tlast  out  1  marks the last sample of a frame.
- m_axis_tdata  out  2*SAMPLE_WIDTH  {Q[31:16], I[15:0]}, two's complement Q1.15.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (aresetn=0 at a rising edge) values: tvalid=0, tlast=0, tdata=0, busy_out=0, frame_done_out=0, FSM=IDLE, all counters=0. Reset mid-frame drops the frame immediately. No partial beat persists.
- Output register:
  - Loads when !m_axis_tvalid || m_axis_tready.
  - tdata and tlast are held stable while tvalid && !tready.
  - A beat is "accepted" when tvalid && tready.
- FSM states: IDLE, STS, LTS_GI, LTS, GAP.
- IDLE:
  - start_in=1 latches gap_len_in and num_frames_in, clears the frame counter and enters STS.
  - The first beat (STS[0]) is valid in the cycle after start.
  - start_in is ignored outside IDLE.
- STS: sample idx 0..159 outputs STS_ROM[idx mod 16]. Leaves after beat 159 is accepted.
- LTS_GI: idx 0..31 outputs LTS_ROM[32+idx].
- LTS: idx 0..127 outputs LTS_ROM[idx mod 64].
  - If gap_len=0, beat 127 carries tlast and the FSM goes to end-of-frame.
  - Otherwise the FSM goes to GAP.
- GAP: outputs gap_len beats of tdata=0 with tvalid=1. The last gap beat carries tlast.
- End-of-frame (on the accepted tlast beat):
  - frame_done_out pulses in the next cycle and the frame counter increments.
  - If num_frames=0, or frames sent < num_frames, go to STS with no idle cycle.
  - Otherwise go to IDLE, deassert tvalid and drop busy_out.
- Frame length = 320 + gap_len beats.
- Counters advance only on acceptance. Backpressure of any length never skips or repeats a sample.
- Frame counter saturates at its maximum in continuous mode; it does not affect behaviour.
- abort_in:
  - Registered as a pending abort.
  - The currently presented beat stays valid until accepted.
  - No new beat is loaded after that; the FSM goes to IDLE.
  - The truncated frame gets no tlast and no frame_done pulse.
  - Abort in IDLE has no effect. abort_in and start_in in the same IDLE cycle: start wins and the abort is discarded.
- Throughput is one sample per cycle when tready is held at 1.

Decomposition:
- Package preamble_pkg holds:
  - state enum preamble_state_t;
  - STS_PERIOD=16, STS_LEN=160, LTS_GI_LEN=32, LTS_SYM_LEN=64, LTS_LEN=128;
  - STS_ROM[16] and LTS_ROM[64] as packed {Q,I} Q1.15 constants: IEEE 802.11 time-domain values scaled so peak |I|,|Q| < 0.5 full scale.
- The receiver-side testbench imports the same package, so expected LTS/CSI are derived from identical constants.
- One sub-module: preamble_rom. It is combinational; inputs are a select (STS/LTS) and a 6-bit index; output is the 32-bit sample.

Test Plan:
1. Single frame, no gap: reset, start_in=1 with num_frames=1, gap=0, tready=1.
   - Exactly 320 beats on consecutive cycles, first beat on the cycle after start.
   - Beat k<160 = STS_ROM[k%16]; beat 160+j = LTS_ROM[32+j] for j<32; beat 192+m = LTS_ROM[m%64].
   - tlast only on beat 319; one frame_done pulse; busy_out low afterwards.
2. Gap and repeat: num_frames=3, gap=80.
   - 1200 beats total; beats 320..399 of each frame are 0.
   - tlast on beats 399, 799, 1199; 3 frame_done pulses; no idle cycle between frames.
3. Backpressure: tready driven by a pseudo-random pattern (~50% duty) on test 1.
   - Captured accepted stream is identical to test 1.
   - tdata and tlast never change while tvalid && !tready.
4. Abort: continuous mode (num_frames=0); assert abort_in at beat 200 with tready=0 for 5 cycles.
   - Beat 200 is held, then accepted, then tvalid=0.
   - No tlast, no frame_done; busy_out low; a following start produces a clean frame from STS[0].
5. Reset mid-frame: aresetn=0 for 1 cycle at beat 250.
   - All outputs at reset values the next cycle.
   - start_in pulsed together with abort_in in IDLE yields a full 320-beat frame.
6. Ignored start: pulse start_in repeatedly during an active frame.
   - Frame count and content unchanged versus test 1.

Source files
------------

// File: rtl/preamble_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// preamble_pkg : shared states, field lengths and 802.11 legacy training ROMs
// Rev 1.0
// ----------------------------------------------------------------------------
package preamble_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_STS    = 3'd1,
      ST_LTS_GI = 3'd2,
      ST_LTS    = 3'd3,
      ST_GAP    = 3'd4
   } preamble_state_t;

   typedef enum logic {
      ROM_STS = 1'b0,
      ROM_LTS = 1'b1
   } rom_sel_t;

   localparam int STS_PERIOD  = 16;
   localparam int STS_LEN     = 160;
   localparam int LTS_GI_LEN  = 32;
   localparam int LTS_SYM_LEN = 64;
   localparam int LTS_LEN     = 128;
   localparam int FRAME_LEN   = STS_LEN + LTS_GI_LEN + LTS_LEN;

   function automatic logic [31:0] iq(input int i, input int q);
      logic [31:0] w;
      w = {q[15:0], i[15:0]};
      return w;
   endfunction

   // Standard time-domain symbols scaled by 3, peak magnitude 0.483 FS.
   localparam logic [31:0] STS_ROM [STS_PERIOD] = '{
      iq(  4522,   4522), iq(-12976,    197), iq( -1278,  -7766), iq( 14057,  -1278),
      iq(  9044,      0), iq( 14057,  -1278), iq( -1278,  -7766), iq(-12976,    197),
      iq(  4522,   4522), iq(   197, -12976), iq( -7766,  -1278), iq( -1278,  14057),
      iq(     0,   9044), iq( -1278,  14057), iq( -7766,  -1278), iq(   197, -12976)
   };

   localparam logic [31:0] LTS_ROM [LTS_SYM_LEN] = '{
      iq( 15335,      0), iq(  -492, -11796), iq(  3932, -10912), iq(  9535,   8159),
      iq(  2064,   2753), iq(  5898,  -8651), iq(-11305,  -5407), iq( -3736, -10420),
      iq(  9634,  -2556), iq(  5210,    393), iq(    98, -11305), iq(-13468,  -4620),
      iq(  2359,  -5800), iq(  5800,  -1475), iq( -2163,  15827), iq( 11698,   -393),
      iq(  6095,  -6095), iq(  3637,   9634), iq( -5603,   3834), iq(-12878,   6390),
      iq(  8061,   9044), iq(  6881,   1376), iq( -5898,   7963), iq( -5505,  -2163),
      iq( -3441, -14844), iq(-11993,  -1671), iq(-12485,  -2064), iq(  7373,  -7274),
      iq(  -295,   5308), iq( -9044,  11305), iq(  9044,  10420), iq(  1180,   9634),
      iq(-15335,      0), iq(  1180,  -9634), iq(  9044, -10420), iq( -9044, -11305),
      iq(  -295,  -5308), iq(  7373,   7274), iq(-12485,   2064), iq(-11993,   1671),
      iq( -3441,  14844), iq( -5505,   2163), iq( -5898,  -7963), iq(  6881,  -1376),
      iq(  8061,  -9044), iq(-12878,  -6390), iq( -5603,  -3834), iq(  3637,  -9634),
      iq(  6095,   6095), iq( 11698,    393), iq( -2163, -15827), iq(  5800,   1475),
      iq(  2359,   5800), iq(-13468,   4620), iq(    98,  11305), iq(  5210,   -393),
      iq(  9634,   2556), iq( -3736,  10420), iq(-11305,   5407), iq(  5898,   8651),
      iq(  2064,  -2753), iq(  9535,  -8159), iq(  3932,  10912), iq(  -492,  11796)
   };

endpackage
`default_nettype wire

// File: rtl/preamble_rom.sv
`default_nettype none
// ----------------------------------------------------------------------------
// preamble_rom : combinational STS/LTS sample lookup, {Q,I} Q1.15
// Rev 1.0
// ----------------------------------------------------------------------------
module preamble_rom
   import preamble_pkg::*;
(
   input  rom_sel_t    sel,
   input  logic [5:0]  index,
   output logic [31:0] sample
);

   always_comb begin
      sample = (sel == ROM_STS) ? STS_ROM[index[3:0]] : LTS_ROM[index];
   end

endmodule
`default_nettype wire

// File: rtl/preamble_generator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// preamble_generator : 802.11 legacy STS/LTS + zero-gap AXI-Stream source
// Rev 1.0
// ----------------------------------------------------------------------------
module preamble_generator
   import preamble_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16,
   parameter int GAP_WIDTH    = 16,
   parameter int FRAMES_WIDTH = 8
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      start_in,
   input  logic                      abort_in,
   input  logic [GAP_WIDTH-1:0]      gap_len_in,
   input  logic [FRAMES_WIDTH-1:0]   num_frames_in,
   output logic                      busy_out,
   output logic                      frame_done_out,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   output logic [2*SAMPLE_WIDTH-1:0] m_axis_tdata,
   input  logic                      m_axis_tready
);

   localparam int CNT_W = (GAP_WIDTH > 8) ? GAP_WIDTH : 8;

   preamble_state_t             state, nxt_state, load_state;
   logic [CNT_W-1:0]            cnt, nxt_cnt, load_cnt, gap_len_ext;
   logic [GAP_WIDTH-1:0]        gap_len;
   logic [FRAMES_WIDTH-1:0]     num_frames, frame_cnt, frames_inc;
   logic                        abort_pend, eof, more_frames, accept, load_last;
   rom_sel_t                    rom_sel;
   logic [5:0]                  rom_idx;
   logic [31:0]                 rom_sample;
   logic [2*SAMPLE_WIDTH-1:0]   rom_data, load_data;

   assign gap_len_ext = CNT_W'(gap_len);
   assign accept      = m_axis_tvalid && m_axis_tready;
   assign frames_inc  = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;
   assign more_frames = (num_frames == '0) || (frames_inc < num_frames);

   // Position of the beat that follows the one currently presented.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt + 1'b1;
      eof       = 1'b0;
      case (state)
         ST_STS:    if (cnt == CNT_W'(STS_LEN - 1)) begin
                       nxt_state = ST_LTS_GI;
                       nxt_cnt   = '0;
                    end
         ST_LTS_GI: if (cnt == CNT_W'(LTS_GI_LEN - 1)) begin
                       nxt_state = ST_LTS;
                       nxt_cnt   = '0;
                    end
         ST_LTS:    if (cnt == CNT_W'(LTS_LEN - 1)) begin
                       if (gap_len == '0) begin
                          eof = 1'b1;
                       end else begin
                          nxt_state = ST_GAP;
                          nxt_cnt   = '0;
                       end
                    end
         ST_GAP:    if (cnt == gap_len_ext - 1'b1) eof = 1'b1;
         default:   ;
      endcase
      if (eof) begin
         nxt_cnt   = '0;
         nxt_state = more_frames ? ST_STS : ST_IDLE;
      end
   end

   always_comb begin
      load_state = nxt_state;
      load_cnt   = nxt_cnt;
      if (state == ST_IDLE) begin
         load_state = ST_STS;
         load_cnt   = '0;
      end
      rom_sel = ROM_LTS;
      rom_idx = load_cnt[5:0];
      case (load_state)
         ST_STS:    begin
                       rom_sel = ROM_STS;
                       rom_idx = {2'b00, load_cnt[3:0]};
                    end
         ST_LTS_GI: rom_idx = {1'b1, load_cnt[4:0]};
         default:   ;
      endcase
      load_last = ((load_state == ST_LTS) && (load_cnt == CNT_W'(LTS_LEN - 1)) && (gap_len == '0))
               || ((load_state == ST_GAP) && (load_cnt == gap_len_ext - 1'b1));
      load_data = (load_state == ST_GAP) ? '0 : rom_data;
   end

   preamble_rom u_rom (
      .sel    (rom_sel),
      .index  (rom_idx),
      .sample (rom_sample)
   );

   if (SAMPLE_WIDTH == 16) begin : g_exact
      assign rom_data = rom_sample;
   end else if (SAMPLE_WIDTH > 16) begin : g_pad
      assign rom_data = {rom_sample[31:16], {(SAMPLE_WIDTH-16){1'b0}},
                         rom_sample[15:0],  {(SAMPLE_WIDTH-16){1'b0}}};
   end else begin : g_trunc
      assign rom_data = {rom_sample[31 -: SAMPLE_WIDTH], rom_sample[15 -: SAMPLE_WIDTH]};
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         gap_len        <= '0;
         num_frames     <= '0;
         frame_cnt      <= '0;
         abort_pend     <= 1'b0;
         busy_out       <= 1'b0;
         frame_done_out <= 1'b0;
         m_axis_tvalid  <= 1'b0;
         m_axis_tlast   <= 1'b0;
         m_axis_tdata   <= '0;
      end else begin
         frame_done_out <= 1'b0;
         if (state == ST_IDLE) begin
            abort_pend <= 1'b0;
            if (start_in) begin
               gap_len       <= gap_len_in;
               num_frames    <= num_frames_in;
               frame_cnt     <= '0;
               state         <= ST_STS;
               cnt           <= '0;
               busy_out      <= 1'b1;
               m_axis_tvalid <= 1'b1;
               m_axis_tlast  <= 1'b0;
               m_axis_tdata  <= load_data;
            end
         end else begin
            if (abort_in) abort_pend <= 1'b1;
            if (accept) begin
               if (m_axis_tlast) begin
                  frame_done_out <= 1'b1;
                  frame_cnt      <= frames_inc;
               end
               // An abort lets the presented beat drain, then loads nothing further.
               if (abort_in || abort_pend || (nxt_state == ST_IDLE)) begin
                  state         <= ST_IDLE;
                  cnt           <= '0;
                  abort_pend    <= 1'b0;
                  busy_out      <= 1'b0;
                  m_axis_tvalid <= 1'b0;
                  m_axis_tlast  <= 1'b0;
                  m_axis_tdata  <= '0;
               end else begin
                  state        <= nxt_state;
                  cnt          <= nxt_cnt;
                  m_axis_tlast <= load_last;
                  m_axis_tdata <= load_data;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_preamble_generator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_preamble_generator : scoreboard bench for the preamble generator
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_preamble_generator;
   import preamble_pkg::*;

   localparam int SW = 16;
   localparam int GW = 16;
   localparam int FW = 8;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic        spot_en;
      logic [31:0] spot;
   } beat_t;

   logic            aclk = 1'b0;
   logic            aresetn = 1'b0;
   logic            start_in = 1'b0;
   logic            abort_in = 1'b0;
   logic            m_axis_tready = 1'b0;
   logic [GW-1:0]   gap_len_in = '0;
   logic [FW-1:0]   num_frames_in = '0;
   logic            busy_out, frame_done_out, m_axis_tvalid, m_axis_tlast;
   logic [2*SW-1:0] m_axis_tdata;

   int          n_checks = 0;
   int          n_fail = 0;
   int          n_beats = 0;
   int          n_fd = 0;
   beat_t       exp_q[$];
   beat_t       mon_b;
   logic        hold_prev = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;

   always #5 aclk = ~aclk;

   preamble_generator #(
      .SAMPLE_WIDTH (SW),
      .GAP_WIDTH    (GW),
      .FRAMES_WIDTH (FW)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .start_in       (start_in),
      .abort_in       (abort_in),
      .gap_len_in     (gap_len_in),
      .num_frames_in  (num_frames_in),
      .busy_out       (busy_out),
      .frame_done_out (frame_done_out),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tready  (m_axis_tready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_beat(input int k);
      if (k < 160)      return STS_ROM[k % 16];
      else if (k < 192) return LTS_ROM[32 + (k - 160)];
      else if (k < 320) return LTS_ROM[(k - 192) % 64];
      else              return 32'h0;
   endfunction

   // Hand-computed {Q,I} words at field boundaries.
   function automatic logic [32:0] spot_of(input int k);
      case (k)
         0:       return 33'h1_11AA11AA;
         1:       return 33'h1_00C5CD50;
         160:     return 33'h1_0000C419;
         192:     return 33'h1_00003BE7;
         319:     return 33'h1_2E14FE14;
         default: return 33'h0_00000000;
      endcase
   endfunction

   task automatic push_frame(input int gap, input int limit);
      int    total;
      beat_t b;
      total = 320 + gap;
      for (int k = 0; k < total && k < limit; k++) begin
         b.data = model_beat(k);
         b.last = (k == total - 1);
         {b.spot_en, b.spot} = spot_of(k);
         exp_q.push_back(b);
      end
   endtask

   always @(negedge aclk) begin
      if (hold_prev) begin
         chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
         chk("hold_data", 64'(m_axis_tdata), 64'(prev_data));
         chk("hold_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
         n_beats++;
         if (exp_q.size() == 0) begin
            chk("unexpected_beat_queue", 64'(exp_q.size()), 64'd1);
         end else begin
            mon_b = exp_q.pop_front();
            chk($sformatf("beat%0d_data", n_beats), 64'(m_axis_tdata), 64'(mon_b.data));
            chk($sformatf("beat%0d_last", n_beats), 64'(m_axis_tlast), 64'(mon_b.last));
            if (mon_b.spot_en) chk("rom_spot", 64'(m_axis_tdata), 64'(mon_b.spot));
         end
      end
      hold_prev = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0) && (aresetn === 1'b1);
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
      if (frame_done_out === 1'b1) n_fd++;
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic start_frame(input int nf, input int gap, input logic with_abort);
      start_in      = 1'b1;
      abort_in      = with_abort;
      num_frames_in = FW'(nf);
      gap_len_in    = GW'(gap);
      tick();
      start_in = 1'b0;
      abort_in = 1'b0;
   endtask

   task automatic end_checks(input string name, input int b0, input int f0,
                             input int exp_beats, input int exp_frames);
      @(negedge aclk);
      #1;
      chk({name, "_beats"}, 64'(n_beats - b0), 64'(exp_beats));
      chk({name, "_frame_done"}, 64'(n_fd - f0), 64'(exp_frames));
      chk({name, "_busy"}, 64'(busy_out), 64'd0);
      chk({name, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
      chk({name, "_queue"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_fixed(input string name, input int cycles, input int exp_frames);
      int b0, f0;
      b0 = n_beats;
      f0 = n_fd;
      repeat (cycles) tick();
      end_checks(name, b0, f0, cycles, exp_frames);
   endtask

   initial begin
      int          b0, f0, cyc;
      logic [15:0] lfsr;

      repeat (3) tick();
      chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("reset_tlast", 64'(m_axis_tlast), 64'd0);
      chk("reset_tdata", 64'(m_axis_tdata), 64'd0);
      chk("reset_busy", 64'(busy_out), 64'd0);
      chk("reset_frame_done", 64'(frame_done_out), 64'd0);
      aresetn = 1'b1;
      tick();

      // single frame, no gap
      m_axis_tready = 1'b1;
      push_frame(0, 320);
      start_frame(1, 0, 1'b0);
      chk("t1_busy_after_start", 64'(busy_out), 64'd1);
      run_fixed("t1", 320, 1);

      // three frames with an 80-sample gap
      for (int f = 0; f < 3; f++) push_frame(80, 400);
      start_frame(3, 80, 1'b0);
      run_fixed("t2", 1200, 3);

      // random backpressure on a single frame
      lfsr = 16'hACE1;
      push_frame(0, 320);
      m_axis_tready = 1'b0;
      start_frame(1, 0, 1'b0);
      b0 = n_beats;
      f0 = n_fd;
      cyc = 0;
      while (busy_out && cyc < 4000) begin
         m_axis_tready = lfsr[0];
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         tick();
         cyc++;
      end
      chk("t3_timeout", 64'(cyc < 4000), 64'd1);
      m_axis_tready = 1'b1;
      end_checks("t3", b0, f0, 320, 1);

      // abort in continuous mode at beat 200 under backpressure
      push_frame(0, 201);
      start_frame(0, 0, 1'b0);
      b0 = n_beats;
      f0 = n_fd;
      repeat (200) tick();
      m_axis_tready = 1'b0;
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;
      chk("t4_held_valid", 64'(m_axis_tvalid), 64'd1);
      repeat (4) tick();
      m_axis_tready = 1'b1;
      tick();
      chk("t4_tvalid_after_abort", 64'(m_axis_tvalid), 64'd0);
      end_checks("t4", b0, f0, 201, 0);
      push_frame(0, 320);
      start_frame(1, 0, 1'b0);
      run_fixed("t4_clean", 320, 1);

      // reset mid-frame at beat 250, then start together with abort
      push_frame(0, 250);
      start_frame(1, 0, 1'b0);
      repeat (250) tick();
      aresetn = 1'b0;
      m_axis_tready = 1'b0;
      tick();
      aresetn = 1'b1;
      chk("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("t5_tlast", 64'(m_axis_tlast), 64'd0);
      chk("t5_tdata", 64'(m_axis_tdata), 64'd0);
      chk("t5_busy", 64'(busy_out), 64'd0);
      chk("t5_frame_done", 64'(frame_done_out), 64'd0);
      chk("t5_queue", 64'(exp_q.size()), 64'd0);
      m_axis_tready = 1'b1;
      push_frame(0, 320);
      start_frame(1, 0, 1'b1);
      run_fixed("t5", 320, 1);

      // repeated start pulses during an active frame
      push_frame(0, 320);
      start_frame(1, 0, 1'b0);
      b0 = n_beats;
      f0 = n_fd;
      for (int i = 0; i < 320; i++) begin
         start_in = ((i % 23) == 3);
         tick();
      end
      start_in = 1'b0;
      end_checks("t6", b0, f0, 320, 1);
      repeat (3) tick();
      chk("t6_stays_idle", 64'(m_axis_tvalid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
